tenyr_irq_ctrl: RTL and testbench
=================================

// Module: tenyr_irq_ctrl
// PURPOSE
//  Interrupt controller between the external irqs[31:0] lines and the Tenyr core.
//  - Latches edge- or level-type requests into a pending register and masks them with an enable register.
//  - Presents the highest-priority enabled pending line to the core over a req/ack/eoi handshake.
//  - Exposes its state to software through a small memory-mapped register port.
// PARAMETERS
//  NIRQ     32   number of interrupt lines (1..32); index 0 = highest priority
//  IRQ_BITS 5    width of irq_num; must satisfy 2**IRQ_BITS >= NIRQ
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  reset     in   1         synchronous, active-low reset
//  irqs      in   NIRQ      raw interrupt lines from the system/bench
//  strobe    in   1         register access request
//  we        in   1         1=write, 0=read; valid with strobe
//  addr      in   2         register select
//  d_in      in   32        write data
//  d_out     out  32        read data, valid while ack=1
//  ack       out  1         one-cycle access acknowledge
//  irq_req   out  1         interrupt request to core
//  irq_num   out  IRQ_BITS  index of the requested line, stable while irq_req=1
//  irq_ack   in   1         core accepts the request (one-cycle pulse)
//  irq_eoi   in   1         core signals end of service (one-cycle pulse)
// BEHAVIOUR
//  Registers
//   - addr 0 PEND: R; W1C; bits >= NIRQ read 0.
//   - addr 1 ENAB: RW.
//   - addr 2 EDGE: RW; 1=edge, 0=level.
//   - addr 3 STAT: RO; bit31=in-service flag, bits[4:0]=in-service index.
//  Reset (reset==0 at posedge)
//   - PEND, ENAB, EDGE, irq_prev = 0.
//   - FSM=IDLE; irq_req=0, irq_num=0, ack=0, d_out=0.
//  Capture, per line i, every cycle
//   - edge mode: set PEND[i] when irqs[i] & ~irq_prev[i].
//   - level mode: PEND[i] <= irqs[i]; W1C has no effect while the line is high.
//   - irq_prev <= irqs.
//   - Same-cycle set and W1C on one bit: set wins.
//  Bus
//   - strobe=1 & ack=0 -> ack=1 on the next cycle, with d_out loaded for reads and the write committed on that edge.
//   - ack is always deasserted the cycle after it is asserted; strobe held high produces one ack per two cycles.
//   - Writes to STAT are ignored, but still acked.
//  Arbitration
//   - cand = PEND & ENAB.
//   - The lowest set index wins; fixed priority, no rotation.
//  FSM IDLE/REQ/SERV
//   - IDLE -> REQ when cand!=0: irq_req=1, irq_num=winner (registered).
//   - REQ holds irq_req and irq_num until irq_ack, even if ENAB/PEND later drop; there is no withdrawal.
//   - REQ & irq_ack -> SERV: irq_req=0; PEND[irq_num] cleared on this edge if edge mode; STAT updated.
//   - SERV & irq_eoi -> IDLE; STAT bit31 cleared.
//   - A new request may issue the cycle after IDLE is re-entered.
//   - Spurious inputs: irq_ack outside REQ is ignored; irq_eoi outside SERV is ignored.
//  Latency: edge on irqs at cycle N -> PEND set at N+1 -> irq_req=1 at N+2.
//  Reset mid-operation (any state) returns to IDLE the next edge and drops irq_req; pending state is lost.
// CONFIGURATION
//  IRQ_SYNC_EN
//   - Defined: irqs passes through a 2-flop synchronizer (reset to 0) before capture; irqs-to-irq_req latency becomes 4 cycles.
//   - Undefined: irqs is sampled directly (synchronous sources only); latency is 2 cycles.
// TESTING (latencies given without IRQ_SYNC_EN)
//  - Reset, then write ENAB=0x1, EDGE=0x1; pulse irqs[0] 2 clocks at N -> irq_req=1, irq_num=0 at N+2.
//  - Ack at M -> PEND=0 and STAT=0x80000000 at M+1.
//  - Edge mode on lines 3 and 7, both enabled, both pulsed in the same cycle:
//    -> irq_num=3 first; after ack+eoi, irq_num=7 one cycle after IDLE.
//  - Level line 5 held high: W1C of PEND bit5 reads back 1.
//  - Level line 5 low then W1C of bit5 -> PEND reads 0; a masked line (ENAB=0) never raises irq_req.
//  - Register port: write ENAB=0xFFFFFFFF, read back 0xFFFFFFFF with ack exactly 1 cycle after strobe.
//  - Write STAT -> read value unchanged.
//  - Drop reset while in REQ -> irq_req=0, PEND=0, ENAB=0 next cycle; stray irq_eoi in IDLE -> no state change.

Source files
------------

// File: rtl/tenyr_irq_ctrl.sv
// tenyr_irq_ctrl: NIRQ-line interrupt controller with a req/ack/eoi core handshake and a
// four-register software port (PEND/ENAB/EDGE/STAT). Define IRQ_SYNC_EN for a 2-flop input synchronizer.
`timescale 1ns/1ps
module tenyr_irq_ctrl #(
   parameter int NIRQ     = 32,
   parameter int IRQ_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NIRQ-1:0]     irqs,
   input  logic                strobe,
   input  logic                we,
   input  logic [1:0]          addr,
   input  logic [31:0]         d_in,
   output logic [31:0]         d_out,
   output logic                ack,
   output logic                irq_req,
   output logic [IRQ_BITS-1:0] irq_num,
   input  logic                irq_ack,
   input  logic                irq_eoi
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_SERV = 2'd2;

   logic [NIRQ-1:0]     pend_r;
   logic [NIRQ-1:0]     enab_r;
   logic [NIRQ-1:0]     edge_r;
   logic [NIRQ-1:0]     prev_r;
   logic [1:0]          state_r;
   logic                serv_r;
   logic [4:0]          serv_idx_r;
   logic [NIRQ-1:0]     irqs_s;
   logic [NIRQ-1:0]     cand_s;
   logic [NIRQ-1:0]     w1c_s;
   logic [NIRQ-1:0]     svc_clr_s;
   logic [NIRQ-1:0]     pend_nxt_s;
   logic                acc_s;
   logic                wr_s;
   logic [31:0]         rd_data_s;
   logic [IRQ_BITS-1:0] win_s;

   function automatic logic [IRQ_BITS-1:0] lowest_set(input logic [NIRQ-1:0] v);
      logic [IRQ_BITS-1:0] idx;
      idx = {IRQ_BITS{1'b0}};
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (v[i]) idx = IRQ_BITS'(i);
      end
      return idx;
   endfunction

`ifdef IRQ_SYNC_EN
   logic [NIRQ-1:0] sync1_r;
   logic [NIRQ-1:0] sync2_r;

   // Two-stage synchronizer for asynchronous interrupt sources
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_r <= {NIRQ{1'b0}};
         sync2_r <= {NIRQ{1'b0}};
      end else begin
         sync1_r <= irqs;
         sync2_r <= sync1_r;
      end
   end
   assign irqs_s = sync2_r;
`else
   assign irqs_s = irqs;
`endif

   // Next-state of the pending bits, arbitration winner and read mux
   always_comb begin
      acc_s  = strobe & ~ack;
      wr_s   = acc_s & we;
      cand_s = pend_r & enab_r;
      win_s  = lowest_set(cand_s);
      if (wr_s && addr == 2'd0) begin
         w1c_s = d_in[NIRQ-1:0];
      end else begin
         w1c_s = {NIRQ{1'b0}};
      end
      for (int i = 0; i < NIRQ; i++) begin
         svc_clr_s[i] = (state_r == S_REQ) && irq_ack && (irq_num == IRQ_BITS'(i));
      end
      // Edge lines: a new rising edge beats any clear on the same cycle; level lines mirror the input.
      pend_nxt_s = (edge_r & ((pend_r & ~w1c_s & ~svc_clr_s) | (irqs_s & ~prev_r)))
                 | (~edge_r & irqs_s);
      case (addr)
         2'd0:    rd_data_s = 32'(pend_r);
         2'd1:    rd_data_s = 32'(enab_r);
         2'd2:    rd_data_s = 32'(edge_r);
         default: rd_data_s = {serv_r, 26'd0, serv_idx_r};
      endcase
   end

   // Register file, capture, bus acknowledge and request/service sequencing
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_r     <= {NIRQ{1'b0}};
         enab_r     <= {NIRQ{1'b0}};
         edge_r     <= {NIRQ{1'b0}};
         prev_r     <= {NIRQ{1'b0}};
         state_r    <= S_IDLE;
         serv_r     <= 1'b0;
         serv_idx_r <= 5'd0;
         irq_req    <= 1'b0;
         irq_num    <= {IRQ_BITS{1'b0}};
         ack        <= 1'b0;
         d_out      <= 32'd0;
      end else begin
         prev_r <= irqs_s;
         pend_r <= pend_nxt_s;
         ack    <= acc_s;
         if (acc_s && !we) d_out <= rd_data_s;
         if (wr_s && addr == 2'd1) enab_r <= d_in[NIRQ-1:0];
         if (wr_s && addr == 2'd2) edge_r <= d_in[NIRQ-1:0];
         case (state_r)
            S_IDLE: begin
               if (cand_s != {NIRQ{1'b0}}) begin
                  state_r <= S_REQ;
                  irq_req <= 1'b1;
                  irq_num <= win_s;
               end
            end
            S_REQ: begin
               if (irq_ack) begin
                  state_r    <= S_SERV;
                  irq_req    <= 1'b0;
                  serv_r     <= 1'b1;
                  serv_idx_r <= 5'(irq_num);
               end
            end
            S_SERV: begin
               if (irq_eoi) begin
                  state_r <= S_IDLE;
                  serv_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= S_IDLE;
               irq_req <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tenyr_irq_ctrl.sv
// Self-checking bench for tenyr_irq_ctrl: register table, directed handshake sequences,
// then randomized traffic against a rule-level reference model.
`timescale 1ns/1ps
module tb_tenyr_irq_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] irqs = 32'd0;
   logic        strobe = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] d_in = 32'd0;
   logic [31:0] d_out;
   logic        ack;
   logic        irq_req;
   logic [4:0]  irq_num;
   logic        irq_ack = 1'b0;
   logic        irq_eoi = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   tenyr_irq_ctrl #(.NIRQ(32), .IRQ_BITS(5)) dut (
      .clk(clk), .reset(reset), .irqs(irqs), .strobe(strobe), .we(we), .addr(addr),
      .d_in(d_in), .d_out(d_out), .ack(ack), .irq_req(irq_req), .irq_num(irq_num),
      .irq_ack(irq_ack), .irq_eoi(irq_eoi)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   // reference model state
   logic [31:0] m_pend, m_enab, m_edge, m_prev, m_dout;
   bit          m_req, m_serv, m_ack;
   int          m_num, m_idx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] rd);
      strobe = 1'b1; we = w; addr = a; d_in = d;
      tick();
      check("ack_rise", 32'(ack), 32'd1);
      rd = d_out;
      strobe = 1'b0; we = 1'b0;
      tick();
      check("ack_fall", 32'(ack), 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] unused;
      bus(1'b1, a, d, unused);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus(1'b0, a, 32'd0, v);
      check(name, v, exp);
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!irq_req && n < 10) begin
         tick();
         n++;
      end
      check(name, 32'(irq_req), 32'd1);
   endtask

   // One clock of the controller expressed as its rules, applied to the currently driven inputs.
   task automatic model_step();
      logic [31:0] cand, nxt, rv;
      bit          acc;
      int          win;
      acc = strobe && !m_ack;
      case (addr)
         2'd0:    rv = m_pend;
         2'd1:    rv = m_enab;
         2'd2:    rv = m_edge;
         default: rv = (m_serv ? 32'h8000_0000 : 32'd0) | 32'(m_idx);
      endcase
      for (int i = 0; i < 32; i++) begin
         if (m_edge[i]) begin
            nxt[i] = m_pend[i];
            if (acc && we && addr == 2'd0 && d_in[i]) nxt[i] = 1'b0;
            if (m_req && irq_ack && m_num == i) nxt[i] = 1'b0;
            if (irqs[i] && !m_prev[i]) nxt[i] = 1'b1;
         end else begin
            nxt[i] = irqs[i];
         end
      end
      cand = m_pend & m_enab;
      win = -1;
      for (int i = 0; i < 32; i++) begin
         if (cand[i]) begin
            win = i;
            break;
         end
      end
      if (!m_req && !m_serv) begin
         if (win >= 0) begin
            m_req = 1'b1;
            m_num = win;
         end
      end else if (m_req) begin
         if (irq_ack) begin
            m_req  = 1'b0;
            m_serv = 1'b1;
            m_idx  = m_num;
         end
      end else if (irq_eoi) begin
         m_serv = 1'b0;
      end
      if (acc && we && addr == 2'd1) m_enab = d_in;
      if (acc && we && addr == 2'd2) m_edge = d_in;
      if (acc && !we) m_dout = rv;
      m_ack  = acc;
      m_pend = nxt;
      m_prev = irqs;
   endtask

   initial begin
      vec_t tbl[8];
      tbl[0] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'd0};
      tbl[1] = '{1'b0, 2'd1, 32'd0,         32'hFFFF_FFFF};
      tbl[2] = '{1'b1, 2'd2, 32'h0000_00A5, 32'd0};
      tbl[3] = '{1'b0, 2'd2, 32'd0,         32'h0000_00A5};
      tbl[4] = '{1'b1, 2'd3, 32'h1234_5678, 32'd0};
      tbl[5] = '{1'b0, 2'd3, 32'd0,         32'd0};
      tbl[6] = '{1'b0, 2'd0, 32'd0,         32'd0};
      tbl[7] = '{1'b1, 2'd1, 32'd0,         32'd0};

      // reset state
      tick();
      tick();
      check("rst_irq_req", 32'(irq_req), 32'd0);
      check("rst_irq_num", 32'(irq_num), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_d_out", d_out, 32'd0);
      reset = 1'b1;
      tick();

      // register port table
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
         else rd_chk($sformatf("tbl_rd%0d", i), tbl[i].a, tbl[i].exp);
      end
      check("tbl_no_req", 32'(irq_req), 32'd0);

      // strobe held high: one ack per two cycles
      strobe = 1'b1; we = 1'b0; addr = 2'd1;
      tick(); check("hold_ack0", 32'(ack), 32'd1);
      tick(); check("hold_ack1", 32'(ack), 32'd0);
      tick(); check("hold_ack2", 32'(ack), 32'd1);
      strobe = 1'b0;
      tick(); check("hold_ack3", 32'(ack), 32'd0);

      // edge line 0: latency and acknowledge
      wr(2'd1, 32'h1);
      wr(2'd2, 32'h1);
      irqs = 32'h1;
      tick(); check("e0_req_n1", 32'(irq_req), 32'd0);
      tick(); check("e0_req_n2", 32'(irq_req), 32'd1);
      check("e0_num", 32'(irq_num), 32'd0);
      irqs = 32'h0;
      irq_ack = 1'b1;
      tick(); irq_ack = 1'b0;
      check("e0_req_drop", 32'(irq_req), 32'd0);
      rd_chk("e0_pend", 2'd0, 32'd0);
      rd_chk("e0_stat", 2'd3, 32'h8000_0000);
      irq_eoi = 1'b1;
      tick(); irq_eoi = 1'b0;
      rd_chk("e0_stat_eoi", 2'd3, 32'h0);

      // lines 3 and 7 in the same cycle: fixed priority, back-to-back issue
      wr(2'd1, 32'h88);
      wr(2'd2, 32'h88);
      irqs = 32'h88;
      tick(); irqs = 32'h0;
      wait_req("p37_req");
      check("p37_first", 32'(irq_num), 32'd3);
      irq_ack = 1'b1;
      tick(); irq_ack = 1'b0;
      rd_chk("p37_stat", 2'd3, 32'h8000_0003);
      irq_eoi = 1'b1;
      tick(); irq_eoi = 1'b0;
      check("p37_idle", 32'(irq_req), 32'd0);
      tick();
      check("p37_second_req", 32'(irq_req), 32'd1);
      check("p37_second", 32'(irq_num), 32'd7);
      irq_ack = 1'b1;
      tick(); irq_ack = 1'b0;
      irq_eoi = 1'b1;
      tick(); irq_eoi = 1'b0;
      rd_chk("p37_pend_clr", 2'd0, 32'd0);

      // level line 5, masked
      wr(2'd1, 32'h0);
      wr(2'd2, 32'h0);
      irqs = 32'h20;
      tick(); tick();
      wr(2'd0, 32'h20);
      rd_chk("lvl_high_w1c", 2'd0, 32'h20);
      check("lvl_masked", 32'(irq_req), 32'd0);
      irqs = 32'h0;
      tick(); tick();
      wr(2'd0, 32'h20);
      rd_chk("lvl_low_w1c", 2'd0, 32'h0);
      check("lvl_masked2", 32'(irq_req), 32'd0);

      // reset while requesting, then stray handshake pulses
      wr(2'd2, 32'h1);
      wr(2'd1, 32'h1);
      irqs = 32'h1;
      tick(); irqs = 32'h0;
      wait_req("mid_req");
      reset = 1'b0;
      tick(); reset = 1'b1;
      check("mid_rst_req", 32'(irq_req), 32'd0);
      rd_chk("mid_rst_pend", 2'd0, 32'h0);
      rd_chk("mid_rst_enab", 2'd1, 32'h0);
      irq_eoi = 1'b1;
      tick(); irq_eoi = 1'b0;
      irq_ack = 1'b1;
      tick(); irq_ack = 1'b0;
      check("stray_req", 32'(irq_req), 32'd0);
      rd_chk("stray_stat", 2'd3, 32'h0);

      // randomized traffic against the model
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      m_pend = 32'd0; m_enab = 32'd0; m_edge = 32'd0; m_prev = 32'd0; m_dout = 32'd0;
      m_req = 1'b0; m_serv = 1'b0; m_ack = 1'b0; m_num = 0; m_idx = 0;
      for (int c = 0; c < 800; c++) begin
         irqs    = irqs ^ ($urandom & $urandom & $urandom);
         strobe  = ($urandom_range(0, 3) == 0);
         we      = $urandom_range(0, 1) == 1;
         addr    = 2'($urandom_range(0, 3));
         d_in    = $urandom;
         irq_ack = ($urandom_range(0, 2) == 0);
         irq_eoi = ($urandom_range(0, 2) == 0);
         model_step();
         tick();
         check("rnd_req", 32'(irq_req), 32'(m_req));
         if (m_req) check("rnd_num", 32'(irq_num), 32'(m_num));
         check("rnd_ack", 32'(ack), 32'(m_ack));
         if (m_ack) check("rnd_dout", d_out, m_dout);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
